// File: rtl/cu_pkg.sv
// Shared decode-stage definitions for the RV32I control unit.
// Opcodes, ALU/branch/immediate codes and the EX control bundle.
package cu_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_XOR   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_AND   = 5'd4;
    localparam logic [4:0] ALU_SLL   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_SLT   = 5'd8;
    localparam logic [4:0] ALU_SLTU  = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd15;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       alu_src_a;
        logic       mem_write;
        logic       jump;
        logic       pc_target_src;
        logic [1:0] result_src;
        logic [2:0] branch;
        logic [4:0] alu_control;
        logic [4:0] rd;
    } ctrl_bundle_t;

    // Integer ALU op from funct3; alt selects SUB/SRA variants
    function automatic logic [4:0] alu_from_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [4:0] r;
        r = ALU_ADD;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational RV32I instruction decoder producing the EX control bundle.
// RV32M decode is enabled by defining CU_M_EXT_EN.
module cu_decode
    import cu_pkg::*;
(
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t ctrl_o,
    output logic [2:0]   imm_src_o,
    output logic [4:0]   rs1_o,
    output logic [4:0]   rs2_o,
    output logic         illegal_o,
    output logic         uses_rs1_o,
    output logic         uses_rs2_o
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_ok;

    assign op    = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign rs1_o = instr_i[19:15];
    assign rs2_o = instr_i[24:20];

    // funct7 is either zero, or the alt encoding on ADD/SUB and SRL/SRA
    assign f7_ok = (f7 == 7'b0000000)
                 | ((f7 == 7'b0100000) & ((f3 == 3'b000) | (f3 == 3'b101)));

    assign uses_rs1_o = ~((op == OP_LUI) | (op == OP_AUIPC) | (op == OP_JAL));
    assign uses_rs2_o = (op == OP_R) | (op == OP_STORE) | (op == OP_BRANCH);

    // Opcode decode; an illegal result wipes every control to zero
    always_comb begin
        ctrl_o    = '0;
        imm_src_o = IMM_I;
        illegal_o = 1'b0;
        ctrl_o.rd = instr_i[11:7];
        case (op)
            OP_LOAD: begin
                ctrl_o.reg_write   = 1'b1;
                ctrl_o.alu_src     = 1'b1;
                ctrl_o.result_src  = RES_MEM;
                ctrl_o.alu_control = ALU_ADD;
                imm_src_o          = IMM_I;
            end
            OP_STORE: begin
                ctrl_o.alu_src     = 1'b1;
                ctrl_o.mem_write   = 1'b1;
                ctrl_o.alu_control = ALU_ADD;
                imm_src_o          = IMM_S;
            end
            OP_R: begin
                ctrl_o.reg_write = 1'b1;
                if (f7 == 7'b0000001) begin
`ifdef CU_M_EXT_EN
                    ctrl_o.alu_control = {2'b10, f3};
`else
                    illegal_o = 1'b1;
`endif
                end else if (!f7_ok) begin
                    illegal_o = 1'b1;
                end else begin
                    ctrl_o.alu_control = alu_from_f3(f3, instr_i[30]);
                end
            end
            OP_I: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                imm_src_o        = IMM_I;
                if (((f3 == 3'b001) | (f3 == 3'b101)) & !f7_ok)
                    illegal_o = 1'b1;
                ctrl_o.alu_control =
                    alu_from_f3(f3, instr_i[30] & (f3 == 3'b101));
            end
            OP_BRANCH: begin
                ctrl_o.alu_control = ALU_SUB;
                imm_src_o          = IMM_B;
                case (f3)
                    3'b000:  ctrl_o.branch = BR_BEQ;
                    3'b001:  ctrl_o.branch = BR_BNE;
                    3'b100:  ctrl_o.branch = BR_BLT;
                    3'b101:  ctrl_o.branch = BR_BGE;
                    3'b110:  ctrl_o.branch = BR_BLTU;
                    3'b111:  ctrl_o.branch = BR_BGEU;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_LUI: begin
                ctrl_o.reg_write   = 1'b1;
                ctrl_o.alu_src     = 1'b1;
                ctrl_o.alu_control = ALU_PASSB;
                imm_src_o          = IMM_U;
            end
            OP_AUIPC: begin
                ctrl_o.reg_write   = 1'b1;
                ctrl_o.alu_src     = 1'b1;
                ctrl_o.alu_src_a   = 1'b1;
                ctrl_o.alu_control = ALU_ADD;
                imm_src_o          = IMM_U;
            end
            OP_JAL: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.jump       = 1'b1;
                ctrl_o.result_src = RES_PC4;
                imm_src_o         = IMM_J;
            end
            OP_JALR: begin
                ctrl_o.reg_write     = 1'b1;
                ctrl_o.alu_src       = 1'b1;
                ctrl_o.jump          = 1'b1;
                ctrl_o.pc_target_src = 1'b1;
                ctrl_o.result_src    = RES_PC4;
                ctrl_o.alu_control   = ALU_ADD;
                imm_src_o            = IMM_I;
            end
            default: illegal_o = 1'b1;
        endcase
        if (illegal_o)
            ctrl_o = '0;
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Decode-stage controller: decoder, ID/EX control register, load-use
// hazard and saturating illegal counter. Optional macro: CU_M_EXT_EN.
module pipelined_control_unit
    import cu_pkg::*;
#(
    parameter int ALUCTRL_W = 5,
    parameter int BR_W      = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr_d,
    input  logic                 instr_valid_d,
    input  logic                 stall_i,
    input  logic                 flush_i,
    output logic [2:0]           imm_src_d,
    output logic                 load_use_stall_o,
    output logic                 valid_e,
    output logic                 illegal_e,
    output logic                 reg_write_e,
    output logic                 alu_src_e,
    output logic                 alu_src_a_e,
    output logic                 mem_write_e,
    output logic                 jump_e,
    output logic                 pc_target_src_e,
    output logic [1:0]           result_src_e,
    output logic [BR_W-1:0]      branch_e,
    output logic [ALUCTRL_W-1:0] alu_control_e,
    output logic [4:0]           rd_e,
    output logic [CNT_W-1:0]     illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_bundle_t     dec;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             dec_illegal;
    logic             uses_rs1;
    logic             uses_rs2;

    ctrl_bundle_t     ex_q, ex_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    cu_decode u_dec (
        .instr_i    (instr_d),
        .ctrl_o     (dec),
        .imm_src_o  (imm_src_d),
        .rs1_o      (rs1),
        .rs2_o      (rs2),
        .illegal_o  (dec_illegal),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2)
    );

    // Load in EX whose destination is read by the instruction in decode
    always_comb begin
        hazard = valid_q
               & (ex_q.result_src == RES_MEM)
               & ex_q.reg_write
               & (ex_q.rd != 5'd0)
               & instr_valid_d
               & ((uses_rs1 & (rs1 == ex_q.rd))
                | (uses_rs2 & (rs2 == ex_q.rd)));
    end

    assign load_use_stall_o = hazard;

    // Next EX contents: flush > stall > hazard bubble > load
    always_comb begin
        ex_d      = ex_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (flush_i) begin
            ex_d      = '0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (stall_i) begin
            ex_d      = ex_q;
        end else if (hazard || !instr_valid_d) begin
            ex_d      = '0;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else begin
            ex_d      = dec;
            valid_d   = 1'b1;
            illegal_d = dec_illegal;
            if (dec_illegal && (cnt_q != CNT_MAX))
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ID/EX control register and illegal counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ex_q      <= ex_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign valid_e         = valid_q;
    assign illegal_e       = illegal_q;
    assign reg_write_e     = ex_q.reg_write;
    assign alu_src_e       = ex_q.alu_src;
    assign alu_src_a_e     = ex_q.alu_src_a;
    assign mem_write_e     = ex_q.mem_write;
    assign jump_e          = ex_q.jump;
    assign pc_target_src_e = ex_q.pc_target_src;
    assign result_src_e    = ex_q.result_src;
    assign branch_e        = BR_W'(ex_q.branch);
    assign alu_control_e   = ALUCTRL_W'(ex_q.alu_control);
    assign rd_e            = ex_q.rd;
    assign illegal_cnt     = cnt_q;

endmodule
